code_lock_fsm: RTL and testbench

Parametrised keypad code lock. It accepts a start keypress and then a sequence of CODE_LEN decimal digits from the keypad decoder. It compares that sequence against a compile-time code and drives the two status LEDs and the digit display. It replaces the fixed 3-digit password machine and adds per-digit display, an entry timeout, timed result phases and a consecutive-failure lockout.

---
 rtl/code_lock_fsm.sv | 194 +++++++++++++++++++
 tb/tb_code_lock_fsm.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/code_lock_fsm.sv
// Keypad code lock: start key, CODE_LEN-digit entry, timed GOOD/BAD phases, entry timeout.
// Define CODE_LOCK_LOCKOUT_EN to compile in the failure counter and LOCKOUT state.
module code_lock_fsm #(
  parameter int                    CODE_LEN      = 3,
  parameter logic [4*CODE_LEN-1:0] CODE          = 12'h259,
  parameter int                    GOOD_TIME     = 3,
  parameter int                    BAD_TIME      = 5,
  parameter int                    ENTRY_TIMEOUT = 10,
  parameter int                    MAX_TRIES     = 3,
  parameter int                    LOCKOUT_TIME  = 30
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tick_1hz,
  input  logic       i_key,
  input  logic [3:0] i_digit,
  input  logic       i_digit_valid,
  output logic [3:0] o_disp,
  output logic [1:0] o_led,
  output logic       o_locked,
  output logic       o_busy
);

  localparam int MAX_GB = (GOOD_TIME > BAD_TIME) ? GOOD_TIME : BAD_TIME;
  localparam int MAX_GE = (MAX_GB > ENTRY_TIMEOUT) ? MAX_GB : ENTRY_TIMEOUT;
  localparam int MAX_T  = (MAX_GE > LOCKOUT_TIME) ? MAX_GE : LOCKOUT_TIME;
  localparam int SEC_W  = $clog2(MAX_T) + 1;
  localparam int IDX_W  = $clog2(CODE_LEN) + 1;

  localparam logic [SEC_W-1:0] GOOD_END = SEC_W'(GOOD_TIME - 1);
  localparam logic [SEC_W-1:0] BAD_END  = SEC_W'(BAD_TIME - 1);
  localparam logic [SEC_W-1:0] TO_END   = SEC_W'(ENTRY_TIMEOUT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ENTRY = 3'd1;
  localparam logic [2:0] S_GOOD  = 3'd2;
  localparam logic [2:0] S_BAD   = 3'd3;
  localparam logic [2:0] S_LOCK  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             mism_q, mism_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic [3:0]       disp_q, disp_d;
  logic             flash_q, flash_d;
  logic [1:0]       led_q, led_d;
  logic             busy_q, busy_d;
  logic             key_q, armed_q;
  logic             lock_hit;

  // armed_q keeps a key held low through reset from counting as a falling edge
  logic start;
  assign start = armed_q & key_q & ~i_key;

  logic [4*CODE_LEN-1:0] code_sh;
  logic [3:0]            code_dig;
  logic                  mism_now, last_dig;
  assign code_sh  = CODE << {idx_q, 2'b00};
  assign code_dig = code_sh[4*CODE_LEN-1 -: 4];
  assign mism_now = mism_q | (i_digit > 4'd9) | (i_digit != code_dig);
  assign last_dig = (idx_q == IDX_W'(CODE_LEN - 1));

`ifdef CODE_LOCK_LOCKOUT_EN
  localparam int               FAIL_W   = $clog2(MAX_TRIES + 1);
  localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_TRIES);
  localparam logic [SEC_W-1:0]  LOCK_END = SEC_W'(LOCKOUT_TIME - 1);
  logic [FAIL_W-1:0] fail_q, fail_d;
  logic              locked_q;
  assign lock_hit = (fail_q == FAIL_MAX);
`else
  assign lock_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mism_d  = mism_q;
    sec_d   = sec_q;
    disp_d  = disp_q;
    flash_d = flash_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ENTRY;
          idx_d   = '0;
          mism_d  = 1'b0;
          disp_d  = '0;
        end
      end
      S_ENTRY: begin
        // a digit beats a coincident tick: the counter restarts instead
        if (i_digit_valid) begin
          disp_d = i_digit;
          mism_d = mism_now;
          idx_d  = idx_q + 1'b1;
          sec_d  = '0;
          if (last_dig) state_d = mism_now ? S_BAD : S_GOOD;
        end else if (i_tick_1hz) begin
          if (ENTRY_TIMEOUT != 0 && sec_q == TO_END) state_d = S_BAD;
          else sec_d = sec_q + 1'b1;
        end
      end
      S_GOOD: begin
        if (i_tick_1hz) begin
          if (sec_q == GOOD_END) state_d = S_IDLE;
          else sec_d = sec_q + 1'b1;
        end
      end
      S_BAD: begin
        if (i_tick_1hz) begin
          flash_d = ~flash_q;
          if (sec_q == BAD_END) state_d = lock_hit ? S_LOCK : S_IDLE;
          else sec_d = sec_q + 1'b1;
        end
      end
`ifdef CODE_LOCK_LOCKOUT_EN
      S_LOCK: begin
        if (i_tick_1hz) begin
          if (sec_q == LOCK_END) state_d = S_IDLE;
          else sec_d = sec_q + 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) sec_d = '0;
    if (state_d == S_BAD && state_q != S_BAD) flash_d = 1'b1;
  end

  always_comb begin
    case (state_d)
      S_ENTRY: led_d = 2'b01;
      S_GOOD:  led_d = 2'b11;
      S_BAD:   led_d = {1'b0, flash_d};
      S_LOCK:  led_d = 2'b10;
      default: led_d = 2'b00;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      mism_q  <= 1'b0;
      sec_q   <= '0;
      disp_q  <= '0;
      flash_q <= 1'b0;
      led_q   <= 2'b00;
      busy_q  <= 1'b0;
      key_q   <= 1'b1;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mism_q  <= mism_d;
      sec_q   <= sec_d;
      disp_q  <= disp_d;
      flash_q <= flash_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      key_q   <= i_key;
      armed_q <= armed_q | i_key;
    end
  end

`ifdef CODE_LOCK_LOCKOUT_EN
  always_comb begin
    fail_d = fail_q;
    if (state_d == S_GOOD && state_q != S_GOOD) fail_d = '0;
    else if (state_d == S_BAD && state_q != S_BAD && fail_q != FAIL_MAX) fail_d = fail_q + 1'b1;
    else if (state_q == S_LOCK && state_d == S_IDLE) fail_d = '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fail_q   <= '0;
      locked_q <= 1'b0;
    end else begin
      fail_q   <= fail_d;
      locked_q <= (state_d == S_LOCK);
    end
  end

  assign o_locked = locked_q;
`else
  assign o_locked = 1'b0;
`endif

  assign o_disp = disp_q;
  assign o_led  = led_q;
  assign o_busy = busy_q;

endmodule

// File: tb/tb_code_lock_fsm.sv
// Randomized bench for code_lock_fsm with a scenario-level reference model (code 2,5,9).
module tb_code_lock_fsm;
  logic       i_clk = 1'b0, i_rst = 1'b1, i_tick_1hz = 1'b0, i_key = 1'b1, i_digit_valid = 1'b0;
  logic [3:0] i_digit = 4'd0;
  logic [3:0] o_disp;
  logic [1:0] o_led;
  logic       o_locked, o_busy;

  localparam int MAXT = 3;
`ifdef CODE_LOCK_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  int n_cmp = 0, n_bad = 0, m_fails = 0;
  logic [3:0] last_disp = 4'd0;

  code_lock_fsm dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_tick_1hz(i_tick_1hz), .i_key(i_key),
    .i_digit(i_digit), .i_digit_valid(i_digit_valid),
    .o_disp(o_disp), .o_led(o_led), .o_locked(o_locked), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic cyc(input int n);
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  task automatic press;
    i_key = 1'b0; cyc(1); i_key = 1'b1;
  endtask

  task automatic key_digit(input logic [3:0] d, input bit with_tick);
    i_digit = d; i_digit_valid = 1'b1; i_tick_1hz = with_tick;
    cyc(1);
    i_digit_valid = 1'b0; i_tick_1hz = 1'b0;
  endtask

  task automatic tick;
    i_tick_1hz = 1'b1; cyc(1); i_tick_1hz = 1'b0;
  endtask

  // idle gap, sometimes with a digit strobe that must be ignored
  task automatic stray;
    cyc($urandom_range(0, 2));
    if ($urandom_range(0, 1) == 1) key_digit(4'($urandom_range(0, 15)), 1'b0);
  endtask

  task automatic do_reset;
    i_rst = 1'b1; cyc(2); i_rst = 1'b0; cyc(1);
    m_fails = 0; last_disp = 4'd0;
  endtask

  task automatic drain_good;
    logic [1:0] exp;
    m_fails = 0;
    for (int k = 1; k <= 3; k++) begin
      stray(); tick();
      exp = (k < 3) ? 2'b11 : 2'b00;
      n_cmp++;
      if (o_led !== exp) begin n_bad++; $display("FAIL good_led tick%0d got=%b exp=%b", k, o_led, exp); end
    end
    n_cmp++;
    if (o_busy !== 1'b0 || o_disp !== last_disp) begin
      n_bad++; $display("FAIL good_end busy=%b disp=%0d exp busy=0 disp=%0d", o_busy, o_disp, last_disp);
    end
  endtask

  task automatic drain_lock;
    for (int k = 1; k <= 30; k++) begin
      if (k == 15) begin
        press();
        n_cmp++;
        if (o_led !== 2'b10 || o_locked !== 1'b1) begin
          n_bad++; $display("FAIL lock_start_ignored led=%b locked=%b exp 10/1", o_led, o_locked);
        end
      end
      stray(); tick();
      n_cmp++;
      if (k < 30 && (o_led !== 2'b10 || o_locked !== 1'b1 || o_busy !== 1'b1)) begin
        n_bad++; $display("FAIL lock_hold tick%0d led=%b locked=%b busy=%b exp 10/1/1", k, o_led, o_locked, o_busy);
      end else if (k == 30 && (o_led !== 2'b00 || o_locked !== 1'b0 || o_busy !== 1'b0)) begin
        n_bad++; $display("FAIL lock_end led=%b locked=%b busy=%b exp 00/0/0", o_led, o_locked, o_busy);
      end
    end
    m_fails = 0;
  endtask

  task automatic drain_bad;
    logic [1:0] exp;
    bit lock;
    m_fails = (m_fails < MAXT) ? m_fails + 1 : MAXT;
    lock = LOCK_EN && (m_fails == MAXT);
    for (int k = 1; k <= 5; k++) begin
      stray(); tick();
      if (k < 5) exp = (k % 2 == 0) ? 2'b01 : 2'b00;
      else exp = lock ? 2'b10 : 2'b00;
      n_cmp++;
      if (o_led !== exp) begin n_bad++; $display("FAIL bad_led tick%0d got=%b exp=%b", k, o_led, exp); end
    end
    n_cmp++;
    if (o_locked !== lock || o_busy !== lock) begin
      n_bad++; $display("FAIL bad_end locked=%b busy=%b exp=%b", o_locked, o_busy, lock);
    end
    if (lock) drain_lock();
  endtask

  task automatic do_entry(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2);
    logic [3:0] d [3];
    bit good;
    d = '{d0, d1, d2};
    good = (d0 == 4'd2) && (d1 == 4'd5) && (d2 == 4'd9);
    press();
    n_cmp++;
    if (o_busy !== 1'b1 || o_led !== 2'b01 || o_disp !== 4'd0) begin
      n_bad++; $display("FAIL start busy=%b led=%b disp=%0d exp 1/01/0", o_busy, o_led, o_disp);
    end
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(0, 2)) begin cyc($urandom_range(0, 2)); tick(); end
      key_digit(d[i], 1'($urandom_range(0, 1)));
      n_cmp++;
      if (o_disp !== d[i]) begin n_bad++; $display("FAIL disp digit%0d got=%0d exp=%0d", i, o_disp, d[i]); end
      n_cmp++;
      if (o_led !== ((i == 2 && good) ? 2'b11 : 2'b01)) begin
        n_bad++; $display("FAIL entry_led digit%0d got=%b good=%0d", i, o_led, good);
      end
    end
    last_disp = d[2];
    if (good) drain_good(); else drain_bad();
  endtask

  task automatic test_reset;
    i_rst = 1'b1; cyc(2);
    n_cmp++;
    if (o_disp !== 4'd0 || o_led !== 2'b00 || o_locked !== 1'b0 || o_busy !== 1'b0) begin
      n_bad++; $display("FAIL reset disp=%0d led=%b locked=%b busy=%b exp all 0", o_disp, o_led, o_locked, o_busy);
    end
    i_rst = 1'b0; cyc(1);
  endtask

  task automatic test_timeout;
    do_reset();
    press(); key_digit(4'd2, 1'b0);
    repeat (9) tick();
    n_cmp++;
    if (o_led !== 2'b01 || o_busy !== 1'b1) begin n_bad++; $display("FAIL to_before led=%b exp=01", o_led); end
    tick();
    last_disp = 4'd2;
    drain_bad();
    press(); key_digit(4'd2, 1'b0);
    repeat (9) tick();
    key_digit(4'd5, 1'b1);
    n_cmp++;
    if (o_disp !== 4'd5 || o_led !== 2'b01) begin
      n_bad++; $display("FAIL to_coincident disp=%0d led=%b exp 5/01", o_disp, o_led);
    end
    repeat (9) tick();
    key_digit(4'd9, 1'b0);
    n_cmp++;
    if (o_led !== 2'b11) begin n_bad++; $display("FAIL to_then_good led=%b exp=11", o_led); end
    last_disp = 4'd9;
    drain_good();
  endtask

  task automatic test_reset_mid;
    press(); key_digit(4'd2, 1'b0); key_digit(4'd5, 1'b0);
    i_rst = 1'b1; cyc(1); i_rst = 1'b0;
    n_cmp++;
    if (o_disp !== 4'd0 || o_led !== 2'b00 || o_locked !== 1'b0 || o_busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid disp=%0d led=%b locked=%b busy=%b exp all 0", o_disp, o_led, o_locked, o_busy);
    end
    key_digit(4'd9, 1'b0);
    n_cmp++;
    if (o_disp !== 4'd0 || o_led !== 2'b00) begin
      n_bad++; $display("FAIL reset_mid_digit disp=%0d led=%b exp 0/00", o_disp, o_led);
    end
    m_fails = 0; last_disp = 4'd0;
  endtask

  task automatic test_key_held;
    i_key = 1'b0; i_rst = 1'b1; cyc(2); i_rst = 1'b0; cyc(3);
    n_cmp++;
    if (o_busy !== 1'b0) begin n_bad++; $display("FAIL key_held busy=%b exp=0", o_busy); end
    i_key = 1'b1; cyc(1); press();
    n_cmp++;
    if (o_busy !== 1'b1 || o_led !== 2'b01) begin
      n_bad++; $display("FAIL key_rearm busy=%b led=%b exp 1/01", o_busy, o_led);
    end
    do_reset();
  endtask

  task automatic test_lockout;
    do_reset();
    repeat (3) do_entry(4'd2, 4'd5, 4'd8);
    do_entry(4'd2, 4'd5, 4'd9);
  endtask

  task automatic test_fail_reset;
    do_reset();
    do_entry(4'd2, 4'd5, 4'd8); do_entry(4'd1, 4'd5, 4'd9);
    do_entry(4'd2, 4'd5, 4'd9);
    do_entry(4'd2, 4'd5, 4'd8); do_entry(4'd12, 4'd5, 4'd9);
  endtask

  task automatic test_random;
    for (int n = 0; n < 10; n++) begin
      if ($urandom_range(0, 1) == 1) do_entry(4'd2, 4'd5, 4'd9);
      else do_entry(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
  endtask

  initial begin
    test_reset();
    do_entry(4'd2, 4'd5, 4'd9);
    do_entry(4'd2, 4'd5, 4'd8);
    test_timeout();
    test_reset_mid();
    test_key_held();
    test_lockout();
    test_fail_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
